addsub_seq_ctrl: RTL



---
 rtl/addsub_seq_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// Byte-serial add/subtract sequencer: drives one 8-bit slice per clock over an
// NBYTES-wide operand and chains the carry; the result is committed whole at the end.
module addsub_seq_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   A,
   input  logic [8*NBYTES-1:0]   B,
   input  logic                  mode,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   out,
   output logic                  cout,
   output logic                  overflow,
   output logic [1:0]            state
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          st;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    work;
   logic [W-1:0]    work_next;
   logic            mode_q;
   logic            carry;
   logic [IW-1:0]   idx;

   logic [7:0]      a_byte;
   logic [7:0]      bx;
   logic [8:0]      sum;
   logic            c7;
   logic            last;

   // One slice of the datapath; subtract inverts B and relies on carry preloaded with mode.
   always_comb begin
      a_byte    = a_q[8*idx +: 8];
      bx        = b_q[8*idx +: 8] ^ {8{mode_q}};
      sum       = {1'b0, a_byte} + {1'b0, bx} + {8'd0, carry};
      c7        = sum[7] ^ a_byte[7] ^ bx[7];
      last      = (idx == IW'(NBYTES - 1));
      work_next = work;
      work_next[8*idx +: 8] = sum[7:0];
   end

   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         work     <= '0;
         mode_q   <= 1'b0;
         carry    <= 1'b0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         out      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= A;
                  b_q    <= B;
                  mode_q <= mode;
                  idx    <= '0;
                  carry  <= mode;
                  busy   <= 1'b1;
                  st     <= RUN;
               end
            end
            RUN: begin
               work  <= work_next;
               carry <= sum[8];
               // Outputs only change here, so partial sums are never visible.
               if (last) begin
                  out      <= work_next;
                  cout     <= sum[8];
                  overflow <= c7 ^ sum[8];
                  done     <= 1'b1;
                  st       <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               st   <= IDLE;
            end
            default: begin
               done <= 1'b0;
               busy <= 1'b0;
               st   <= IDLE;
            end
         endcase
      end
   end

endmodule
